ac_quant_pool: RTL and testbench
================================

Name: ac_quant_pool

Overview:
- Output stage directly downstream of the accumulate/BN/ReLU unit.
- Consumes its wide signed result (data_out with data_out_en) and rescales it by an arithmetic right shift with rounding.
- Saturates the result to the activation width and optionally max-pools over N consecutive valid samples.
- Buffers results in a small FIFO with a valid/ready handshake towards the write-back/packing logic.

Parameters:
- IN_WIDTH, 35: width of the signed input from the accumulate stage.
- OUT_WIDTH, 16: width of the signed quantized output activation.
- SHIFT_WIDTH, 6: width of the shift-amount configuration field.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; the block has one clock.
- rst  input  1  reset; asynchronous and active-low.
- data_in  input  IN_WIDTH  signed result from the accumulate stage.
- data_in_en  input  1  data_in is valid this cycle; no backpressure upstream.
- shift_amt  input  SHIFT_WIDTH  right-shift amount, 0..IN_WIDTH-1; quasi-static.
- pool_en  input  1  1 = max-pool enabled, 0 = pass-through.
- pool_size  input  3  samples per pool group, 1..4; values 0 and >4 are treated as 1.
- flush  input  1  single-cycle pulse; emits any partial pool group.
- clr_ovf  input  1  clears the sticky overflow flag.
- out_data  output  OUT_WIDTH  FIFO head.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data.
- sat_flag  output  1  sticky: set when any sample saturated.
- ovf_flag  output  1  sticky: set when a result was dropped because the FIFO was full.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous) clears all state and outputs:
  - out_valid=0, out_data=0, fifo_count=0, sat_flag=0, ovf_flag=0.
  - Pool counter and running max are cleared; the stage-1 valid flag is cleared.
  - A reset asserted mid-group discards the partial group and all FIFO contents.
- Stage 1, quantize, registered with 1-cycle latency after data_in_en:
  - If s=shift_amt>0: r = (data_in + 2^(s-1)) >>> s, computed at IN_WIDTH+1 bits so the rounding add cannot overflow. If s=0: r = data_in.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - On clamp, set sat_flag. It stays set until reset; clr_ovf clears ovf_flag only.
- Stage 2, pool, registered:
  - pool_en=0 or effective size 1: every stage-1 result is pushed to the FIFO 1 cycle later. Total latency data_in_en to FIFO write is 2 cycles; out_valid is seen on cycle 3 if the FIFO was empty.
  - pool_en=1, size N: pool_size is latched when the first sample of a group arrives.
  - The running max uses a signed compare; on a tie the earlier value is kept.
  - The counter increments on each stage-1 valid. When it reaches N, max(group) is pushed and the counter is cleared in the same cycle. A sample arriving in that cycle cannot occur, because the push happens on the Nth sample itself.
  - Changing pool_size or pool_en mid-group takes effect from the next group.
  - flush with counter>0: the partial max is pushed and the counter is cleared.
  - If flush coincides with a stage-1 valid, the sample is included first, then the group is emitted.
  - flush with counter=0: no push.
- FIFO:
  - Push occurs when stage 2 emits.
  - Pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push while full without a pop: the result is dropped and ovf_flag is set.
  - Empty with pop: no effect, since out_valid=0.
  - out_data is the registered head and is stable while out_valid=1 and out_ready=0.
- clr_ovf=1 clears ovf_flag. If an overflow event occurs in the same cycle, the set wins.

Test Plan:
- Reset, pass-through: pool_en=0, shift_amt=4, data_in=100 with one data_in_en pulse → out_valid on cycle 3, out_data=6 ((100+8)>>4), sat_flag=0.
- Saturation: shift_amt=0, inputs 40000 then -40000 → out_data 32767 then -32768; sat_flag=1.
- Max-pool: pool_en=1, pool_size=4, inputs -5, 7, 3, 7 → exactly one output, value 7; then inputs 1, 2 followed by a flush pulse → one output, value 2.
- Backpressure: out_ready=0, 6 pass-through samples 1..6 → fifo_count=4, ovf_flag=1; FIFO holds 1..4; clr_ovf clears the flag; out_ready=1 drains 1, 2, 3, 4 in order.
- Full with simultaneous push/pop: FIFO full, out_ready=1 while a new sample arrives → no drop, ovf_flag stays 0, fifo_count stays 4.
- Asynchronous reset mid-group: pool_size=4, 2 samples, then rst low between clock edges → outputs clear immediately; after release, a new 4-sample group produces the correct max with no stale data.

Source files
------------

// File: rtl/ac_quant_pool_if.sv
// Output stream from the quantize/pool stage towards write-back/packing.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
// out_data is held stable while out_valid=1 and out_ready=0, and out_valid never
// drops without a transfer.
interface ac_quant_pool_if #(
  parameter int OUT_WIDTH = 16
);
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ac_quant_pool.sv
// Output stage after accumulate/BN/ReLU: rounding right shift, saturation to the
// activation width, optional max-pool over N samples, and a small output FIFO.
module ac_quant_pool #(
  parameter int IN_WIDTH    = 35,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [IN_WIDTH-1:0]    data_in,
  input  logic                          data_in_en,
  input  logic [SHIFT_WIDTH-1:0]        shift_amt,
  input  logic                          pool_en,
  input  logic [2:0]                    pool_size,
  input  logic                          flush,
  input  logic                          clr_ovf,
  ac_quant_pool_if.master               out,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int EW = IN_WIDTH + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_WIDTH){1'b0}}, OUT_MAX};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_WIDTH){1'b1}}, OUT_MIN};

  // ---------------------------------------------------------------------------
  // Stage 1: rounding shift and saturation, one extra bit of headroom
  // ---------------------------------------------------------------------------
  logic signed [EW-1:0]        ext;
  logic signed [EW-1:0]        rnd;
  logic signed [EW-1:0]        shifted;
  logic                        clamp_hi;
  logic                        clamp_lo;
  logic signed [OUT_WIDTH-1:0] quant;

  always_comb begin
    ext      = {data_in[IN_WIDTH-1], data_in};
    rnd      = '0;
    if (shift_amt != '0) begin
      rnd = EW'(1) <<< (shift_amt - SHIFT_WIDTH'(1));
    end
    shifted  = (ext + rnd) >>> shift_amt;
    clamp_hi = shifted > SAT_MAX;
    clamp_lo = shifted < SAT_MIN;
    quant    = shifted[OUT_WIDTH-1:0];
    if (clamp_hi) begin
      quant = OUT_MAX;
    end else if (clamp_lo) begin
      quant = OUT_MIN;
    end
  end

  logic                        s1_valid;
  logic signed [OUT_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      sat_flag <= 1'b0;
    end else begin
      s1_valid <= data_in_en;
      if (data_in_en) begin
        s1_data <= quant;
        if (clamp_hi || clamp_lo) begin
          sat_flag <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: max-pool. Group size is captured with the first sample of a group,
  // so config changes mid-group only affect the following group.
  // ---------------------------------------------------------------------------
  logic [2:0]                  pool_cnt;
  logic [2:0]                  pool_n;
  logic signed [OUT_WIDTH-1:0] pool_max;

  logic [2:0]                  eff_size;
  logic [2:0]                  grp_n;
  logic [2:0]                  cnt_inc;
  logic signed [OUT_WIDTH-1:0] cand;
  logic                        emit;
  logic signed [OUT_WIDTH-1:0] emit_data;
  logic [2:0]                  nxt_cnt;
  logic [2:0]                  nxt_n;
  logic signed [OUT_WIDTH-1:0] nxt_max;

  always_comb begin
    eff_size = pool_size;
    if (!pool_en || pool_size == 3'd0 || pool_size > 3'd4) begin
      eff_size = 3'd1;
    end
    grp_n     = (pool_cnt == 3'd0) ? eff_size : pool_n;
    cnt_inc   = pool_cnt + 3'd1;
    // Strict compare keeps the earlier value on a tie.
    cand      = (pool_cnt == 3'd0 || s1_data > pool_max) ? s1_data : pool_max;
    emit      = 1'b0;
    emit_data = pool_max;
    nxt_cnt   = pool_cnt;
    nxt_n     = pool_n;
    nxt_max   = pool_max;
    if (s1_valid) begin
      nxt_n   = grp_n;
      nxt_max = cand;
      if (cnt_inc == grp_n || flush) begin
        emit      = 1'b1;
        emit_data = cand;
        nxt_cnt   = 3'd0;
      end else begin
        nxt_cnt = cnt_inc;
      end
    end else if (flush && pool_cnt != 3'd0) begin
      emit      = 1'b1;
      emit_data = pool_max;
      nxt_cnt   = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pool_cnt <= 3'd0;
      pool_n   <= 3'd1;
      pool_max <= '0;
    end else begin
      pool_cnt <= nxt_cnt;
      pool_n   <= nxt_n;
      pool_max <= nxt_max;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO; stage 2 writes straight into it so the entry is the stage-2
  // register. A push into a full FIFO succeeds only if the head leaves together.
  // ---------------------------------------------------------------------------
  logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic                        full;
  logic                        pop;
  logic                        push_ok;
  logic                        drop;

  always_comb begin
    full    = (count == CW'(FIFO_DEPTH));
    pop     = (count != '0) && out.out_ready;
    push_ok = emit && (!full || pop);
    drop    = emit && full && !pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= emit_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Overflow event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_flag <= 1'b0;
    end else if (drop) begin
      ovf_flag <= 1'b1;
    end else if (clr_ovf) begin
      ovf_flag <= 1'b0;
    end
  end

  assign out.out_data  = mem[rd_ptr];
  assign out.out_valid = (count != '0);
  assign fifo_count    = count;

endmodule

// File: tb/tb_ac_quant_pool.sv
// Scoreboard bench for ac_quant_pool: directed scenarios plus randomized segments
// against a queue-based reference model.
module tb_ac_quant_pool;
  localparam int IW = 35;
  localparam int OW = 16;
  localparam int SW = 6;
  localparam int FD = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [IW-1:0]  data_in;
  logic                  data_in_en;
  logic [SW-1:0]         shift_amt;
  logic                  pool_en;
  logic [2:0]            pool_size;
  logic                  flush;
  logic                  clr_ovf;
  logic                  sat_flag;
  logic                  ovf_flag;
  logic [$clog2(FD):0]   fifo_count;

  ac_quant_pool_if #(.OUT_WIDTH(OW)) oif ();

  ac_quant_pool #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_en(data_in_en),
    .shift_amt(shift_amt), .pool_en(pool_en), .pool_size(pool_size),
    .flush(flush), .clr_ovf(clr_ovf),
    .out(oif),
    .sat_flag(sat_flag), .ovf_flag(ovf_flag), .fifo_count(fifo_count)
  );

  // scoreboard state
  int             errors = 0;
  int             checks = 0;
  logic [OW-1:0]  exp_q[$];
  longint         grp[$];
  int             grp_n = 1;
  bit             exp_sat = 1'b0;
  bit             model_keep = 1'b1;
  bit             ready_rand = 1'b0;
  bit             ready_lvl = 1'b1;
  logic [OW-1:0]  mon_exp;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model
  function automatic int eff_size(input bit pe, input logic [2:0] ps);
    if (!pe || ps == 3'd0 || ps > 3'd4) return 1;
    return int'(ps);
  endfunction

  function automatic longint quantize(input longint x, input int s);
    longint hi = (longint'(1) <<< (OW - 1)) - 1;
    longint lo = -(longint'(1) <<< (OW - 1));
    longint r;
    if (s == 0) r = x;
    else r = (x + (longint'(1) <<< (s - 1))) >>> s;
    if (r > hi) begin
      exp_sat = 1'b1;
      r = hi;
    end else if (r < lo) begin
      exp_sat = 1'b1;
      r = lo;
    end
    return r;
  endfunction

  task automatic emit_group();
    longint m = grp[0];
    foreach (grp[i]) if (grp[i] > m) m = grp[i];
    grp.delete();
    if (model_keep) exp_q.push_back(OW'(m));
  endtask

  task automatic model_step(input bit fl, input bit en, input longint x);
    longint q;
    if (fl && grp.size() > 0) emit_group();
    if (en) begin
      q = quantize(x, int'(shift_amt));
      if (grp.size() == 0) grp_n = eff_size(pool_en, pool_size);
      grp.push_back(q);
      if (grp.size() == grp_n) emit_group();
    end
  endtask

  // driver
  task automatic drive_cycle(input bit en, input longint x, input bit fl, input bit clr);
    data_in_en    = en;
    data_in       = IW'(x);
    flush         = fl;
    clr_ovf       = clr;
    oif.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_lvl;
    model_step(fl, en, x);
    @(posedge clk);
    #1;
    data_in_en = 1'b0;
    flush      = 1'b0;
    clr_ovf    = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || oif.out_valid); i++) begin
      drive_cycle(1'b0, 0, 1'b0, 1'b0);
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", oif.out_valid, 0);
  endtask

  function automatic longint rand_data();
    logic [63:0] r = {$urandom, $urandom};
    longint v = $signed(r);
    return ($urandom_range(0, 1) != 0) ? (v >>> 29) : (v >>> 45);
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst && oif.out_valid && oif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data: got %0d expected no output", $signed(oif.out_data));
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", $signed(oif.out_data), $signed(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 1'b1;
    data_in = '0; data_in_en = 1'b0; shift_amt = '0; pool_en = 1'b0;
    pool_size = 3'd1; flush = 1'b0; clr_ovf = 1'b0; oif.out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", oif.out_valid, 0);
    check("rst_data", oif.out_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ovf", ovf_flag, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // pass-through latency and rounding
    shift_amt = 6'd4;
    drive_cycle(1'b1, 100, 1'b0, 1'b0);
    check("lat_c2_valid", oif.out_valid, 0);
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check("lat_c3_valid", oif.out_valid, 1);
    wait_drain();
    check("pt_sat", sat_flag, 0);

    // saturation
    shift_amt = 6'd0;
    drive_cycle(1'b1, 40000, 1'b0, 1'b0);
    drive_cycle(1'b1, -40000, 1'b0, 1'b0);
    wait_drain();
    check("sat_flag", sat_flag, 1);

    // max-pool, then partial group closed by a flush coinciding with stage 1
    pool_en = 1'b1; pool_size = 3'd4;
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    drive_cycle(1'b1, -5, 1'b0, 1'b0);
    drive_cycle(1'b1, 7, 1'b0, 1'b0);
    drive_cycle(1'b1, 3, 1'b0, 1'b0);
    drive_cycle(1'b1, 7, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1, 1'b0, 1'b0);
    drive_cycle(1'b1, 2, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 1'b1, 1'b0);
    wait_drain();
    drive_cycle(1'b0, 0, 1'b1, 1'b0);
    wait_drain();

    // backpressure and overflow
    pool_en = 1'b0; ready_lvl = 1'b0;
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      model_keep = (i <= FD);
      drive_cycle(1'b1, i, 1'b0, 1'b0);
    end
    model_keep = 1'b1;
    repeat (3) drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check("bp_count", fifo_count, FD);
    check("bp_ovf", ovf_flag, 1);
    check("bp_head", $signed(oif.out_data), 1);
    drive_cycle(1'b0, 0, 1'b0, 1'b1);
    check("bp_head_stable", $signed(oif.out_data), 1);
    check("clr_ovf", ovf_flag, 0);
    ready_lvl = 1'b1;
    wait_drain();

    // push and pop together while full
    ready_lvl = 1'b0;
    for (int i = 10; i <= 13; i++) drive_cycle(1'b1, i, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check("full_count", fifo_count, FD);
    drive_cycle(1'b1, 14, 1'b0, 1'b0);
    ready_lvl = 1'b1;
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check("pp_count", fifo_count, FD);
    check("pp_ovf", ovf_flag, 0);
    wait_drain();

    // asynchronous reset mid-group
    ready_lvl = 1'b0; model_keep = 1'b0;
    drive_cycle(1'b1, 55, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    pool_en = 1'b1; pool_size = 3'd4;
    drive_cycle(1'b0, 0, 1'b0, 1'b0);
    drive_cycle(1'b1, -3, 1'b0, 1'b0);
    drive_cycle(1'b1, 9, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, 0, 1'b0, 1'b0);
    check("pre_rst_count", fifo_count, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", oif.out_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_data", oif.out_data, 0);
    check("arst_sat", sat_flag, 0);
    grp.delete(); exp_sat = 1'b0; model_keep = 1'b1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    ready_lvl = 1'b1;
    drive_cycle(1'b1, 4, 1'b0, 1'b0);
    drive_cycle(1'b1, -2, 1'b0, 1'b0);
    drive_cycle(1'b1, 8, 1'b0, 1'b0);
    drive_cycle(1'b1, 8, 1'b0, 1'b0);
    wait_drain();

    // randomized segments; input gated so the FIFO cannot overflow
    ready_rand = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      shift_amt = SW'($urandom_range(0, 20));
      pool_en   = ($urandom_range(0, 1) != 0);
      pool_size = 3'($urandom_range(0, 7));
      repeat (2) drive_cycle(1'b0, 0, 1'b0, 1'b0);
      for (int c = 0; c < 150; c++) begin
        bit en = ($urandom_range(0, 1) != 0) &&
                 (exp_q.size() + ((grp.size() > 0) ? 1 : 0) < FD);
        drive_cycle(en, rand_data(), ($urandom_range(0, 7) == 0), 1'b0);
      end
      drive_cycle(1'b0, 0, 1'b1, 1'b0);
      wait_drain();
      check("rand_ovf", ovf_flag, 0);
      check("rand_sat", sat_flag, exp_sat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
